// File: rtl/pow2_pkg.sv
// -----------------------------------------------------------------------------
// pow2_pkg
// Shared types and default widths for the pow2 stage, the pow2_accum reducer
// and their benches.
//   accum_state_e : reducer FSM states (eIdle, eAccum, eDone)
//   POW2_WIDTH    : default element width from pow2
//   SUM_WIDTH     : default accumulator width
//   LEN_WIDTH     : default group-length width
// -----------------------------------------------------------------------------
package pow2_pkg;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eAccum = 2'd1,
        eDone  = 2'd2
    } accum_state_e;

    localparam int unsigned POW2_WIDTH = 32;
    localparam int unsigned SUM_WIDTH  = 40;
    localparam int unsigned LEN_WIDTH  = 8;

endpackage

// File: rtl/pow2_sat_add.sv
// -----------------------------------------------------------------------------
// pow2_sat_add
// Combinational unsigned saturating adder: a_i + zero-extended b_i.
// Ports:
//   a_i   [sum_width_p-1:0] running sum
//   b_i   [width_p-1:0]     element to add (unsigned)
//   sum_o [sum_width_p-1:0] a_i + b_i, clamped to all ones on overflow
//   ovf_o                   carry out of the sum_width_p-bit add
// -----------------------------------------------------------------------------
module pow2_sat_add
    import pow2_pkg::*;
#(
    parameter int unsigned width_p     = POW2_WIDTH,
    parameter int unsigned sum_width_p = SUM_WIDTH
) (
    input  logic [sum_width_p-1:0] a_i,
    input  logic [width_p-1:0]     b_i,
    output logic [sum_width_p-1:0] sum_o,
    output logic                   ovf_o
);

    // One extra bit holds the carry; the MSB of the wide sum is the overflow.
    function automatic logic [sum_width_p:0] sat_add(
        input logic [sum_width_p-1:0] a,
        input logic [width_p-1:0]     b
    );
        logic [sum_width_p:0] wide;
        wide = (sum_width_p+1)'(a) + (sum_width_p+1)'(b);
        if (wide[sum_width_p]) begin
            sat_add = {1'b1, {sum_width_p{1'b1}}};
        end else begin
            sat_add = wide;
        end
    endfunction

    logic [sum_width_p:0] res;

    always_comb begin
        res   = sat_add(a_i, b_i);
        sum_o = res[sum_width_p-1:0];
        ovf_o = res[sum_width_p];
    end

endmodule

// File: rtl/pow2_accum.sv
// -----------------------------------------------------------------------------
// pow2_accum
// Sums groups of len_i consecutive pow2 results into one saturating wide sum.
// Ports:
//   clk_i      clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   len_i      group length, sampled on the first accept of a group (0 -> 1)
//   data_i     unsigned element
//   v_i        data_i/len_i valid
//   ready_o    element can be accepted this cycle
//   sum_o      group sum (saturating), valid with v_o
//   ovf_o      group sum saturated, valid with v_o
//   v_o        sum_o/ovf_o valid
//   yumi_i     consumer takes sum_o (only meaningful while v_o=1)
// -----------------------------------------------------------------------------
module pow2_accum
    import pow2_pkg::*;
#(
    parameter int unsigned width_p     = POW2_WIDTH,
    parameter int unsigned sum_width_p = SUM_WIDTH,
    parameter int unsigned len_width_p = LEN_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [len_width_p-1:0] len_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [sum_width_p-1:0] sum_o,
    output logic                   ovf_o,
    output logic                   v_o,
    input  logic                   yumi_i
);

    accum_state_e           state_q, state_d;
    logic [sum_width_p-1:0] sum_q, sum_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic [sum_width_p-1:0] add_sum;
    logic                   add_ovf;
    logic [len_width_p-1:0] leff;
    logic                   accept;

    pow2_sat_add #(
        .width_p     (width_p),
        .sum_width_p (sum_width_p)
    ) u_sat_add (
        .a_i   (sum_q),
        .b_i   (data_i),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // A zero length is treated as a one-element group.
    assign leff   = (len_i == '0) ? len_width_p'(1) : len_i;
    assign accept = v_i & ready_o;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eIdle;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            eIdle: begin
                if (accept) begin
                    sum_d   = sum_width_p'(data_i);
                    ovf_d   = 1'b0;
                    cnt_d   = leff - len_width_p'(1);
                    state_d = (leff == len_width_p'(1)) ? eDone : eAccum;
                end
            end
            eAccum: begin
                if (accept) begin
                    sum_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = eDone;
                    end
                end
            end
            eDone: begin
                if (yumi_i) begin
                    state_d = eIdle;
                end
            end
            default: begin
                state_d = eIdle;
            end
        endcase
    end

    // Handshake outputs depend only on state and reset, never on v_i/yumi_i.
    always_comb begin
        ready_o = 1'b0;
        v_o     = 1'b0;
        unique case (state_q)
            eIdle, eAccum: ready_o = reset_n_i;
            eDone:         v_o     = 1'b1;
            default: begin
                ready_o = 1'b0;
                v_o     = 1'b0;
            end
        endcase
    end

    assign sum_o = sum_q;
    assign ovf_o = ovf_q;

endmodule
